// File: rtl/conv_lb_multi.sv
// conv_lb_multi: multi-line buffer for the conv pipeline.
// Keeps the previous LINES_N lines in LINES_N rotating banks (PACK_N pixels
// per word). For each accepted pixel it emits a column of LINES_N+1 pixels:
// slice 0 is the current pixel, slice k is the pixel at the same x in line r-k.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_vld_i/in_rdy_o input pixel handshake; in_dat_i pixel, in_sof_i/in_eol_i framing
//   out_vld_o/out_rdy_i output column handshake
//   out_col_o         (LINES_N+1) pixel slices, slice 0 = current pixel
//   out_row_vld_o     bit k set when line r-k exists in the current frame
//   out_sof_o/out_eol_o framing aligned with the column (eol includes forced eol)
//   ovf_o             one-cycle pulse when a line hits IMAGE_MAX_W without eol
module conv_lb_multi #(
    parameter int PIXEL_W     = 8,
    parameter int LINES_N     = 2,
    parameter int IMAGE_MAX_W = 1024,
    parameter int SRAM_W      = 128
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld_i,
    output logic                             in_rdy_o,
    input  logic [PIXEL_W-1:0]               in_dat_i,
    input  logic                             in_sof_i,
    input  logic                             in_eol_i,
    output logic                             out_vld_o,
    input  logic                             out_rdy_i,
    output logic [(LINES_N+1)*PIXEL_W-1:0]   out_col_o,
    output logic [LINES_N:0]                 out_row_vld_o,
    output logic                             out_sof_o,
    output logic                             out_eol_o,
    output logic                             ovf_o
);
    localparam int PACK_N  = SRAM_W / PIXEL_W;
    localparam int WORDS_N = (IMAGE_MAX_W + PACK_N - 1) / PACK_N;
    localparam int XW = (IMAGE_MAX_W > 1) ? $clog2(IMAGE_MAX_W) : 1;
    localparam int SW = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int AW = (WORDS_N > 1) ? $clog2(WORDS_N) : 1;
    localparam int BW = (LINES_N > 1) ? $clog2(LINES_N) : 1;
    localparam int RW = $clog2(LINES_N + 1);
    localparam int CW = (LINES_N + 1) * PIXEL_W;

    logic [XW-1:0]     x_q, x_eff;
    logic [SW-1:0]     slot_q, slot_eff;
    logic [AW-1:0]     addr_q, addr_eff;
    logic [BW-1:0]     wr_bnk_q, bnk_eff, bnk_inc;
    logic [RW-1:0]     row_q, row_eff, row_inc;
    logic [SRAM_W-1:0] word_q, word_nxt;
    logic [LINES_N:0]  rowv_nxt;

    logic acc, s1_adv, rd_en, wr_en, ovf_hit, eol_eff;

    logic               s1_vld_q, rd_pend_q, ovf_q;
    logic [PIXEL_W-1:0] s1_pix_q;
    logic [SW-1:0]      s1_slot_q;
    logic [BW-1:0]      s1_bnk_q;
    logic [LINES_N:0]   s1_rowv_q;
    logic               s1_sof_q, s1_eol_q;

    logic               out_vld_q, out_sof_q, out_eol_q;
    logic [CW-1:0]      out_col_q, col_nxt;
    logic [LINES_N:0]   out_rowv_q;

    logic [SRAM_W-1:0]  mem_q   [LINES_N][WORDS_N];
    logic [SRAM_W-1:0]  dout_q  [LINES_N];
    logic [SRAM_W-1:0]  hold_q  [LINES_N];
    logic [SRAM_W-1:0]  sel_word[LINES_N];

    // Bank holding line r-k while line r is being written into bank wb.
    // For k == LINES_N this is wb itself: the oldest line, read before overwrite.
    function automatic logic [BW-1:0] slice_bank(input logic [BW-1:0] wb, input int k);
        int s;
        s = int'(wb) + LINES_N - k;
        if (s >= LINES_N) s = s - LINES_N;
        return BW'(s);
    endfunction

    // Only out_rdy_i reaches in_rdy_o combinationally.
    assign s1_adv   = s1_vld_q & (~out_vld_q | out_rdy_i);
    assign in_rdy_o = ~s1_vld_q | ~out_vld_q | out_rdy_i;
    assign acc      = in_vld_i & in_rdy_o & ~rst;

    // sof restarts the line counters for the pixel that carries it.
    assign x_eff    = in_sof_i ? '0 : x_q;
    assign slot_eff = in_sof_i ? '0 : slot_q;
    assign addr_eff = in_sof_i ? '0 : addr_q;
    assign bnk_eff  = in_sof_i ? '0 : wr_bnk_q;
    assign row_eff  = in_sof_i ? '0 : row_q;

    assign ovf_hit = (x_eff == XW'(IMAGE_MAX_W - 1)) & ~in_eol_i;
    assign eol_eff = in_eol_i | ovf_hit;
    assign rd_en   = acc & (slot_eff == '0);
    assign wr_en   = acc & (eol_eff | (slot_eff == SW'(PACK_N - 1)));

    assign bnk_inc = (bnk_eff == BW'(LINES_N - 1)) ? '0 : bnk_eff + 1'b1;
    assign row_inc = (row_eff == RW'(LINES_N)) ? row_eff : row_eff + 1'b1;

    // A new word starts from zero so a partial word at eol is zero-filled.
    always_comb begin
        word_nxt = (slot_eff == '0) ? '0 : word_q;
        word_nxt[slot_eff*PIXEL_W +: PIXEL_W] = in_dat_i;
    end

    always_comb begin
        rowv_nxt = '0;
        for (int k = 0; k <= LINES_N; k++) rowv_nxt[k] = (k <= int'(row_eff));
    end

    // Raw bank output is only valid the cycle right after the read.
    always_comb begin
        for (int b = 0; b < LINES_N; b++) sel_word[b] = rd_pend_q ? dout_q[b] : hold_q[b];
    end

    always_comb begin
        col_nxt = '0;
        col_nxt[PIXEL_W-1:0] = s1_pix_q;
        for (int k = 1; k <= LINES_N; k++) begin
            if (s1_rowv_q[k])
                col_nxt[k*PIXEL_W +: PIXEL_W] =
                    sel_word[slice_bank(s1_bnk_q, k)][s1_slot_q*PIXEL_W +: PIXEL_W];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < LINES_N; b++) begin
            if (rd_en) dout_q[b] <= mem_q[b][addr_eff];
            if (wr_en && (bnk_eff == BW'(b))) mem_q[b][addr_eff] <= word_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend_q) hold_q <= dout_q;
        if (acc) begin
            word_q    <= word_nxt;
            s1_pix_q  <= in_dat_i;
            s1_slot_q <= slot_eff;
            s1_bnk_q  <= bnk_eff;
            s1_rowv_q <= rowv_nxt;
            s1_sof_q  <= in_sof_i;
            s1_eol_q  <= eol_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            slot_q     <= '0;
            addr_q     <= '0;
            wr_bnk_q   <= '0;
            row_q      <= '0;
            s1_vld_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_col_q  <= '0;
            out_rowv_q <= '0;
            out_sof_q  <= 1'b0;
            out_eol_q  <= 1'b0;
        end else begin
            ovf_q     <= acc & ovf_hit;
            rd_pend_q <= rd_en;
            if (acc) begin
                if (eol_eff) begin
                    x_q      <= '0;
                    slot_q   <= '0;
                    addr_q   <= '0;
                    wr_bnk_q <= bnk_inc;
                    row_q    <= row_inc;
                end else begin
                    x_q      <= x_eff + 1'b1;
                    slot_q   <= (slot_eff == SW'(PACK_N - 1)) ? '0 : slot_eff + 1'b1;
                    addr_q   <= (slot_eff == SW'(PACK_N - 1)) ? addr_eff + 1'b1 : addr_eff;
                    wr_bnk_q <= bnk_eff;
                    row_q    <= row_eff;
                end
            end
            if (acc)         s1_vld_q <= 1'b1;
            else if (s1_adv) s1_vld_q <= 1'b0;
            if (s1_adv) begin
                out_vld_q  <= 1'b1;
                out_col_q  <= col_nxt;
                out_rowv_q <= s1_rowv_q;
                out_sof_q  <= s1_sof_q;
                out_eol_q  <= s1_eol_q;
            end else if (out_rdy_i) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign out_vld_o     = out_vld_q;
    assign out_col_o     = out_col_q;
    assign out_row_vld_o = out_rowv_q;
    assign out_sof_o     = out_sof_q;
    assign out_eol_o     = out_eol_q;
    assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_conv_lb_multi.sv
module tb_conv_lb_multi;
    localparam int PW   = 8;
    localparam int LN   = 2;
    localparam int MAXW = 1024;
    localparam int SRW  = 128;
    localparam int PK   = SRW / PW;
    localparam int CW   = (LN + 1) * PW;

    logic clk = 1'b0;
    logic rst;
    logic in_vld_i, in_rdy_o, in_sof_i, in_eol_i;
    logic [PW-1:0] in_dat_i;
    logic out_vld_o, out_rdy_i, out_sof_o, out_eol_o, ovf_o;
    logic [CW-1:0] out_col_o;
    logic [LN:0] out_row_vld_o;

    always #5 clk = ~clk;

    conv_lb_multi #(.PIXEL_W(PW), .LINES_N(LN), .IMAGE_MAX_W(MAXW), .SRAM_W(SRW)) dut (
        .clk(clk), .rst(rst),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i),
        .in_sof_i(in_sof_i), .in_eol_i(in_eol_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_col_o(out_col_o),
        .out_row_vld_o(out_row_vld_o), .out_sof_o(out_sof_o), .out_eol_o(out_eol_o),
        .ovf_o(ovf_o)
    );

    typedef struct {
        logic [CW-1:0] col;
        logic [CW-1:0] mask;
        logic [LN:0]   rowv;
        logic          sof;
        logic          eol;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovf_seen = 0;
    int ovf_exp  = 0;
    int rdy_mode = 0;
    bit lat_chk  = 0;

    // Reference: the frame as a history of whole lines (line r-1 at index 0).
    int m_rows;
    int m_cur_len;
    int m_cur[MAXW];
    int m_hist[LN][MAXW];
    int m_hlen[LN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_push(input int pix, input bit sof, input bit eol);
        exp_t e;
        int x, v;
        bit force_eol;
        if (sof) begin
            m_rows = 0;
            m_cur_len = 0;
        end
        x = m_cur_len;
        force_eol = (x == MAXW - 1) && !eol;
        if (force_eol) ovf_exp++;
        e.col = '0;
        e.mask = '1;
        e.rowv = '0;
        e.col[PW-1:0] = PW'(pix);
        e.rowv[0] = 1'b1;
        for (int k = 1; k <= LN; k++) begin
            if (k <= m_rows) begin
                e.rowv[k] = 1'b1;
                v = 0;
                if (x < m_hlen[k-1]) v = m_hist[k-1][x];
                else if (x / PK != (m_hlen[k-1] - 1) / PK) e.mask[k*PW +: PW] = '0;
                e.col[k*PW +: PW] = PW'(v);
            end
        end
        e.sof = sof;
        e.eol = eol | force_eol;
        e.cyc = cyc;
        e.lat = lat_chk;
        exp_q.push_back(e);
        m_cur[x] = pix;
        m_cur_len++;
        if (eol || force_eol) begin
            for (int k = LN - 1; k >= 1; k--) begin
                m_hlen[k] = m_hlen[k-1];
                for (int i = 0; i < m_hlen[k]; i++) m_hist[k][i] = m_hist[k-1][i];
            end
            m_hlen[0] = m_cur_len;
            for (int i = 0; i < m_cur_len; i++) m_hist[0][i] = m_cur[i];
            m_cur_len = 0;
            if (m_rows < LN) m_rows++;
        end
    endtask

    task automatic send(input int pix, input bit sof, input bit eol);
        int t = 0;
        in_vld_i = 1'b1;
        in_dat_i = PW'(pix);
        in_sof_i = sof;
        in_eol_i = eol;
        @(negedge clk);
        while (!in_rdy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_rdy_timeout: got in_rdy_o=0 expected 1 within 200 cycles");
        end else begin
            model_push(pix, sof, eol);
        end
        @(posedge clk); #1;
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
        in_eol_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // base < 0 selects random pixels, otherwise pixel = base + x.
    task automatic send_line(input int w, input bit sof, input int base, input int gmax);
        for (int x = 0; x < w; x++) begin
            if (gmax > 0) idle(int'($urandom_range(0, gmax)));
            send(base < 0 ? int'($urandom_range(0, 255)) : ((base + x) & 255), sof && (x == 0), x == w - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    logic [CW-1:0] p_col;
    logic [LN:0]   p_rowv;
    logic          p_sof, p_eol;
    bit            p_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_stall = 0;
        end else begin
            if (p_stall) begin
                chk("stall_vld", out_vld_o, 1);
                chk("stall_col", out_col_o, p_col);
                chk("stall_row_vld", out_row_vld_o, p_rowv);
                chk("stall_sof_eol", {out_sof_o, out_eol_o}, {p_sof, p_eol});
            end
            if (out_vld_o && out_rdy_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_column: got col 0x%0h expected no column", out_col_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("col", out_col_o & mon_e.mask, mon_e.col & mon_e.mask);
                    chk("row_vld", out_row_vld_o, mon_e.rowv);
                    chk("sof", out_sof_o, mon_e.sof);
                    chk("eol", out_eol_o, mon_e.eol);
                    if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 2);
                end
            end
            if (ovf_o) ovf_seen++;
            p_stall = out_vld_o && !out_rdy_i;
            p_col   = out_col_o;
            p_rowv  = out_row_vld_o;
            p_sof   = out_sof_o;
            p_eol   = out_eol_o;
        end
    end

    initial begin
        out_rdy_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_rdy_i = 1'b1;
                1: out_rdy_i = ~out_rdy_i;
                2: out_rdy_i = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
        in_eol_i = 1'b0;
        in_dat_i = '0;
        m_rows = 0;
        m_cur_len = 0;
        for (int k = 0; k < LN; k++) m_hlen[k] = 0;
        idle(3);
        rst = 1'b0;
        chk("reset_out_vld", out_vld_o, 0);
        chk("reset_out_col", out_col_o, 0);
        chk("reset_row_vld", out_row_vld_o, 0);
        chk("reset_sof_eol_ovf", {out_sof_o, out_eol_o, ovf_o}, 3'b000);
        chk("reset_in_rdy", in_rdy_o, 1);

        // Three lines of width 20, pixel = 16*row + x, no stalls.
        rdy_mode = 0;
        lat_chk = 1;
        for (int r = 0; r < 3; r++) send_line(20, r == 0, 16 * r, 0);
        drain();
        lat_chk = 0;

        // Same stream, out_rdy toggling 1010 and random input gaps.
        rdy_mode = 1;
        for (int r = 0; r < 3; r++) send_line(20, r == 0, 16 * r, 0);
        for (int r = 0; r < 3; r++) send_line(20, r == 0, 16 * r, 2);
        drain();

        // Width 16, 5, 16: zero-filled partial word under slice 1.
        rdy_mode = 2;
        send_line(16, 1, -1, 1);
        send_line(5, 0, -1, 1);
        send_line(16, 0, -1, 1);
        drain();

        // Four lines then a new frame: history must be masked off.
        for (int r = 0; r < 4; r++) send_line(20, r == 0, 16 * r, 1);
        send_line(20, 1, 100, 1);
        send_line(20, 0, 116, 1);
        drain();

        // Line without eol reaching IMAGE_MAX_W.
        rdy_mode = 0;
        send_line(20, 1, -1, 0);
        for (int x = 0; x < MAXW; x++) send(int'($urandom_range(0, 255)), 0, 0);
        send_line(5, 0, -1, 0);
        send_line(20, 0, -1, 0);
        drain();
        chk("ovf_count", ovf_seen, ovf_exp);

        // Reset with both pipeline stages full.
        rdy_mode = 3;
        out_rdy_i = 1'b0;
        send(8'h5a, 1, 0);
        send(8'ha5, 0, 0);
        chk("pre_rst_out_vld", out_vld_o, 1);
        chk("pre_rst_in_rdy", in_rdy_o, 0);
        rst = 1'b1;
        exp_q.delete();
        m_rows = 0;
        m_cur_len = 0;
        idle(1);
        chk("rst_out_vld", out_vld_o, 0);
        chk("rst_in_rdy", in_rdy_o, 1);
        rst = 1'b0;
        rdy_mode = 2;
        for (int r = 0; r < 3; r++) send_line(20, r == 0, -1, 1);
        drain();

        // Random frames, including 1-pixel lines (sof and eol together).
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) send_line(int'($urandom_range(1, 40)), r == 0, -1, 2);
            send_line(1, 1, -1, 1);
            send_line(int'($urandom_range(1, 40)), 0, -1, 2);
        end
        drain();
        chk("ovf_count_final", ovf_seen, ovf_exp);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
